// File: rtl/memory_responder_pkg.sv
// Shared types for the data-memory responder: bus cycle width encodings used by the pipeline
// request interface and the lane steering logic.
package memory_responder_pkg;

    typedef enum logic [1:0] {
        CW_LONG     = 2'd0,
        CW_WORD     = 2'd1,
        CW_BYTE     = 2'd2,
        CW_RESERVED = 2'd3
    } t_cycle_width;

    localparam int WAIT_COUNT_BITS = 4;

    function automatic logic width_is_legal(input t_cycle_width width);
        return width != CW_RESERVED;
    endfunction

endpackage

// File: rtl/memory_lane_steer.sv
// Big-endian byte-lane steering between right-justified request data and the 32-bit RAM.
// Byte offset 0 lives in bits 31:24, offset 3 in bits 7:0.
module memory_lane_steer
    import memory_responder_pkg::*;
(
    input  t_cycle_width width,
    input  logic [1:0]   offset,
    input  logic [31:0]  write_data,
    input  logic [31:0]  read_data,
    output logic [3:0]   byte_enable,
    output logic [31:0]  write_lanes,
    output logic [31:0]  read_justified,
    output logic         misalign
);

    always_comb begin
        byte_enable    = 4'b0000;
        write_lanes    = '0;
        read_justified = '0;
        misalign       = 1'b0;
        case (width)
            CW_BYTE: begin
                byte_enable = 4'b1000 >> offset;
                write_lanes = {4{write_data[7:0]}};
                case (offset)
                    2'd0:    read_justified = {24'h0, read_data[31:24]};
                    2'd1:    read_justified = {24'h0, read_data[23:16]};
                    2'd2:    read_justified = {24'h0, read_data[15:8]};
                    default: read_justified = {24'h0, read_data[7:0]};
                endcase
            end
            CW_WORD: begin
                misalign       = offset[0];
                byte_enable    = offset[1] ? 4'b0011 : 4'b1100;
                write_lanes    = {2{write_data[15:0]}};
                read_justified = offset[1] ? {16'h0, read_data[15:0]}
                                           : {16'h0, read_data[31:16]};
            end
            CW_LONG: begin
                misalign       = (offset != 2'd0);
                byte_enable    = 4'b1111;
                write_lanes    = write_data;
                read_justified = read_data;
            end
            default: begin
                byte_enable = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/memory_responder.sv
// Target end of the data-memory request interface: one request at a time, alignment check,
// wait-stated access to a synchronous 32-bit big-endian RAM, then a single response pulse.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int WAIT_STATES = 1,
    parameter int RAM_ABITS   = 30
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    input  logic                 req_read,
    input  logic                 req_write,
    input  logic [1:0]           req_width,
    input  logic [31:0]          req_address,
    input  logic [31:0]          req_write_data,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [31:0]          resp_read_data,
    output logic                 bus_error,
    output logic                 ram_cs,
    output logic                 ram_we,
    output logic [RAM_ABITS-1:0] ram_address,
    output logic [3:0]           ram_byte_enable,
    output logic [31:0]          ram_write_data,
    input  logic [31:0]          ram_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } t_state;

    localparam logic [WAIT_COUNT_BITS-1:0] WAIT_LOAD = WAIT_COUNT_BITS'(WAIT_STATES);

    t_state                     state;
    t_cycle_width               width_reg;
    logic [1:0]                 offset_reg;
    logic                       read_reg;
    logic [WAIT_COUNT_BITS-1:0] wait_count;

    t_cycle_width steer_width;
    logic [1:0]   steer_offset;
    logic [3:0]   steer_enable;
    logic [31:0]  steer_write;
    logic [31:0]  steer_read;
    logic         steer_misalign;
    logic         decode_error;

    // The steering block decodes the live request while idle and the captured one afterwards.
    always_comb begin
        steer_width  = width_reg;
        steer_offset = offset_reg;
        if (state == ST_IDLE) begin
            steer_width  = t_cycle_width'(req_width);
            steer_offset = req_address[1:0];
        end
    end

    memory_lane_steer steer (
        .width          (steer_width),
        .offset         (steer_offset),
        .write_data     (req_write_data),
        .read_data      (ram_read_data),
        .byte_enable    (steer_enable),
        .write_lanes    (steer_write),
        .read_justified (steer_read),
        .misalign       (steer_misalign)
    );

    assign decode_error = (req_read == req_write)
                       || !width_is_legal(t_cycle_width'(req_width))
                       || steer_misalign;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            bus_error       <= 1'b0;
            resp_read_data  <= '0;
            ram_cs          <= 1'b0;
            ram_we          <= 1'b0;
            ram_address     <= '0;
            ram_byte_enable <= '0;
            ram_write_data  <= '0;
            wait_count      <= '0;
            width_reg       <= CW_LONG;
            offset_reg      <= '0;
            read_reg        <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            bus_error  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        width_reg  <= t_cycle_width'(req_width);
                        offset_reg <= req_address[1:0];
                        read_reg   <= req_read;
                        req_ready  <= 1'b0;
                        if (decode_error) begin
                            // Rejected requests skip the RAM and answer on the next clock.
                            state          <= ST_RESPOND;
                            resp_valid     <= 1'b1;
                            bus_error      <= 1'b1;
                            resp_read_data <= '0;
                        end else begin
                            state           <= ST_ACCESS;
                            ram_cs          <= 1'b1;
                            ram_we          <= req_write;
                            ram_address     <= req_address[RAM_ABITS+1:2];
                            ram_byte_enable <= steer_enable;
                            ram_write_data  <= steer_write;
                            wait_count      <= WAIT_LOAD;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (wait_count == '0) begin
                        state          <= ST_RESPOND;
                        ram_cs         <= 1'b0;
                        ram_we         <= 1'b0;
                        resp_valid     <= 1'b1;
                        resp_read_data <= read_reg ? steer_read : 32'h0;
                    end else begin
                        wait_count <= wait_count - 1'b1;
                    end
                end
                ST_RESPOND: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    ram_cs    <= 1'b0;
                    ram_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule
